// File: rtl/trap_redirect.sv
// Trap/return sequencer: decodes ECALL/MRET, stalls and flushes the pipeline,
// drains memory and CSR traffic, then issues a held PC redirect to fetch.
module trap_redirect #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             valid,
    input  logic [31:0]      pc,
    input  logic [31:0]      ir,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc,
    input  logic             mem_busy,
    input  logic             redir_ack,
    output logic             stall,
    output logic             flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             busy,
    output logic [CNT_W-1:0] trap_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;

    localparam logic [3:0] DRAIN_MAX = 4'(DRAIN_CYCLES);

    logic [1:0] state;
    logic [3:0] drain_cnt;
    logic [3:0] drain_next;
    logic       drain_done;
    logic       is_mret;
    logic       flush_q;
    logic       sys_dec;
    logic       ecall_dec;
    logic       mret_dec;
    logic       trap_hit;

    // Only the SYSTEM opcode, funct3 and funct12 fields matter to the decode.
    logic       unused_bits;
    assign unused_bits = ^{pc, ir[19:15], ir[11:7], ir[1:0]};

    always_comb begin
        sys_dec    = valid && (ir[6:2] == 5'b11100) && (ir[14:12] == 3'b000);
        ecall_dec  = sys_dec && (ir[31:20] == 12'h000);
        mret_dec   = sys_dec && (ir[31:20] == 12'h302);
        trap_hit   = (state == IDLE) && !halt && (ecall_dec || mret_dec);
        drain_next = (drain_cnt == DRAIN_MAX) ? drain_cnt : drain_cnt + 4'd1;
        drain_done = (drain_next == DRAIN_MAX) && !mem_busy;
    end

    // Exit is decided on the count reached this cycle, so DRAIN lasts
    // exactly DRAIN_CYCLES cycles when memory is already quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= 4'd0;
            is_mret    <= 1'b0;
            flush_q    <= 1'b0;
            redir_pc   <= 32'd0;
            trap_count <= '0;
        end else begin
            flush_q <= trap_hit;
            if (!halt) begin
                case (state)
                    IDLE: begin
                        if (trap_hit) begin
                            state     <= DRAIN;
                            drain_cnt <= 4'd0;
                            is_mret   <= mret_dec;
                            redir_pc  <= mret_dec ? (mepc & ~32'h3) : (mtvec & ~32'h3);
                        end
                    end
                    DRAIN: begin
                        drain_cnt <= drain_next;
                        if (drain_done) begin
                            state <= REDIR;
                            // mepc is re-read here so a just-committed CSR write is seen.
                            if (is_mret) begin
                                redir_pc <= mepc & ~32'h3;
                            end
                        end
                    end
                    REDIR: begin
                        if (redir_ack) begin
                            state      <= IDLE;
                            trap_count <= trap_count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        stall       = trap_hit || (state != IDLE);
        redir_valid = (state == REDIR);
        flush       = flush_q;
    end

endmodule

// File: tb/tb_trap_redirect.sv
// Self-checking bench for trap_redirect: directed scenarios plus randomized
// traps checked against a transaction-level timing model.
module tb_trap_redirect;

    localparam int DRAIN = 2;
    localparam int CNT_W = 32;

    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] MRET   = 32'h30200073;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] CSRRW  = 32'h30529073;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             halt;
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      mtvec;
    logic [31:0]      mepc;
    logic             mem_busy;
    logic             redir_ack;
    logic             stall;
    logic             flush;
    logic             redir_valid;
    logic [31:0]      redir_pc;
    logic             busy;
    logic [CNT_W-1:0] trap_count;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_count;

    trap_redirect #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .valid(valid), .pc(pc), .ir(ir),
        .mtvec(mtvec), .mepc(mepc), .mem_busy(mem_busy), .redir_ack(redir_ack),
        .stall(stall), .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .busy(busy), .trap_count(trap_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0; valid = 1'b0; pc = '0; ir = '0;
        mtvec = '0; mepc = '0; mem_busy = 1'b0; redir_ack = 1'b0;
        exp_count = '0;
        #1;
        n_cmp++; if ({stall, flush, redir_valid, busy} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {stall, flush, redir_valid, busy}); end
        n_cmp++; if (redir_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want 0", redir_pc); end
        n_cmp++; if (trap_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", trap_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ecall();
        int first_valid, flush_n, flush_at;
        logic [31:0] pc_seen;
        first_valid = -1; flush_n = 0; flush_at = -1; pc_seen = '0;
        @(negedge clk);
        valid = 1'b1; ir = ECALL; pc = 32'h100; mtvec = 32'h203; mem_busy = 1'b0; redir_ack = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL ecall_detect_stall: got %b want 1", stall); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            valid = 1'b0;
            #1;
            if (flush === 1'b1) begin flush_n++; flush_at = c; end
            if (redir_valid === 1'b1 && first_valid < 0) begin first_valid = c; pc_seen = redir_pc; end
        end
        exp_count = exp_count + 1;
        n_cmp++; if (flush_n !== 1 || flush_at !== 1) begin n_fail++; $display("[TB] FAIL ecall_flush: got %0d pulses at %0d want 1 at 1", flush_n, flush_at); end
        n_cmp++; if (first_valid !== 3) begin n_fail++; $display("[TB] FAIL ecall_latency: got %0d want 3", first_valid); end
        n_cmp++; if (pc_seen !== 32'h200) begin n_fail++; $display("[TB] FAIL ecall_target: got %h want 00000200", pc_seen); end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL ecall_count: got %0d want %0d", trap_count, exp_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ecall_idle: got busy %b want 0", busy); end
        redir_ack = 1'b0;
    endtask

    task automatic test_mret();
        int first_valid;
        logic [31:0] pc_seen;
        first_valid = -1; pc_seen = '0;
        @(negedge clk);
        valid = 1'b1; ir = MRET; mepc = 32'h104; mem_busy = 1'b0; redir_ack = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            valid = 1'b0;
            if (c == 1) mepc = 32'h108;
            #1;
            if (redir_valid === 1'b1 && first_valid < 0) begin first_valid = c; pc_seen = redir_pc; end
        end
        exp_count = exp_count + 1;
        n_cmp++; if (first_valid !== 3) begin n_fail++; $display("[TB] FAIL mret_latency: got %0d want 3", first_valid); end
        n_cmp++; if (pc_seen !== 32'h108) begin n_fail++; $display("[TB] FAIL mret_target: got %h want 00000108", pc_seen); end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL mret_count: got %0d want %0d", trap_count, exp_count); end
        redir_ack = 1'b0;
    endtask

    task automatic test_drain_stall();
        int first_valid, stall_low;
        first_valid = -1; stall_low = 0;
        @(negedge clk);
        valid = 1'b1; ir = ECALL; mtvec = 32'h400; mem_busy = 1'b0; redir_ack = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            valid = 1'b0;
            mem_busy = (c <= 10);
            #1;
            if (first_valid < 0 && stall !== 1'b1) stall_low++;
            if (redir_valid === 1'b1 && first_valid < 0) first_valid = c;
        end
        mem_busy = 1'b0;
        exp_count = exp_count + 1;
        n_cmp++; if (first_valid !== 12) begin n_fail++; $display("[TB] FAIL drain_latency: got %0d want 12", first_valid); end
        n_cmp++; if (stall_low !== 0) begin n_fail++; $display("[TB] FAIL drain_stall: got %0d low cycles want 0", stall_low); end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL drain_count: got %0d want %0d", trap_count, exp_count); end
        redir_ack = 1'b0;
    endtask

    task automatic test_handshake();
        int nv, first_valid, pc_moved, cnt_moved;
        logic [31:0] pc0;
        nv = 0; first_valid = -1; pc_moved = 0; cnt_moved = 0; pc0 = '0;
        @(negedge clk);
        valid = 1'b1; ir = ECALL; mtvec = 32'h30000001; mem_busy = 1'b0; redir_ack = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            valid = 1'b0;
            #1;
            if (redir_valid === 1'b1) begin
                nv++;
                if (first_valid < 0) begin first_valid = c; pc0 = redir_pc; end
                else if (redir_pc !== pc0) pc_moved++;
                if (trap_count !== exp_count) cnt_moved++;
            end
            redir_ack = (redir_valid === 1'b1) && (nv >= 6);
        end
        redir_ack = 1'b0;
        exp_count = exp_count + 1;
        n_cmp++; if (first_valid !== 3) begin n_fail++; $display("[TB] FAIL hs_latency: got %0d want 3", first_valid); end
        n_cmp++; if (nv !== 6) begin n_fail++; $display("[TB] FAIL hs_valid_cycles: got %0d want 6", nv); end
        n_cmp++; if (pc0 !== 32'h30000000) begin n_fail++; $display("[TB] FAIL hs_target: got %h want 30000000", pc0); end
        n_cmp++; if (pc_moved !== 0) begin n_fail++; $display("[TB] FAIL hs_pc_stable: got %0d changes want 0", pc_moved); end
        n_cmp++; if (cnt_moved !== 0) begin n_fail++; $display("[TB] FAIL hs_count_early: got %0d changes want 0", cnt_moved); end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL hs_count: got %0d want %0d", trap_count, exp_count); end
    endtask

    task automatic test_halt();
        int first_valid, flush_n;
        first_valid = -1; flush_n = 0;
        @(negedge clk);
        valid = 1'b1; ir = ECALL; mtvec = 32'h500; mem_busy = 1'b0; redir_ack = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            valid = 1'b0;
            halt = (c >= 2 && c <= 4);
            #1;
            if (flush === 1'b1) flush_n++;
            if (redir_valid === 1'b1 && first_valid < 0) first_valid = c;
        end
        halt = 1'b0;
        redir_ack = 1'b0;
        exp_count = exp_count + 1;
        n_cmp++; if (first_valid !== 6) begin n_fail++; $display("[TB] FAIL halt_latency: got %0d want 6", first_valid); end
        n_cmp++; if (flush_n !== 1) begin n_fail++; $display("[TB] FAIL halt_flush: got %0d pulses want 1", flush_n); end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL halt_count: got %0d want %0d", trap_count, exp_count); end
    endtask

    task automatic test_non_trap();
        logic [31:0] pats [3];
        logic        vals [3];
        pats[0] = EBREAK; pats[1] = CSRRW; pats[2] = ECALL;
        vals[0] = 1'b1;   vals[1] = 1'b1;  vals[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = vals[i]; ir = pats[i]; mem_busy = 1'b0; redir_ack = 1'b0;
            #1;
            n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL nontrap_stall_%0d: got %b want 0", i, stall); end
            @(negedge clk);
            valid = 1'b0;
            #1;
            n_cmp++; if ({busy, flush} !== 2'b00) begin n_fail++; $display("[TB] FAIL nontrap_busy_flush_%0d: got %b want 00", i, {busy, flush}); end
        end
        n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL nontrap_count: got %0d want %0d", trap_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        int waited;
        waited = 0;
        @(negedge clk);
        valid = 1'b1; ir = ECALL; mtvec = 32'h600; mem_busy = 1'b0; redir_ack = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        #1;
        while (redir_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_cmp++; if (redir_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_reach_redir: got %b want 1", redir_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({stall, flush, redir_valid, busy} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rstmid_flags: got %b want 0000", {stall, flush, redir_valid, busy}); end
        n_cmp++; if (redir_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_pc: got %h want 0", redir_pc); end
        n_cmp++; if (trap_count !== '0) begin n_fail++; $display("[TB] FAIL rstmid_count: got %0d want 0", trap_count); end
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if ({busy, redir_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid_after: got %b want 00", {busy, redir_valid}); end
    endtask

    // Model: redirect appears once DRAIN cycles have elapsed and memory is
    // quiet, stays up for (ack delay + 1) cycles, and targets the aligned
    // mtvec seen at detect (ECALL) or the aligned mepc seen at REDIR entry (MRET).
    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int          kind, k, d, exp_first;
            int          nv, first_valid, flush_n, stall_low, pc_moved, back_idle;
            logic        acked, done;
            logic [31:0] tv, ev, tv2, ev2, exp_pc, pc0;
            kind = $urandom_range(0, 1); k = $urandom_range(0, 6); d = $urandom_range(0, 4);
            tv = $urandom; ev = $urandom; tv2 = $urandom; ev2 = $urandom;
            exp_pc = (kind == 1) ? (ev2 & ~32'h3) : (tv & ~32'h3);
            exp_first = (((k + 1) > DRAIN) ? (k + 1) : DRAIN) + 1;
            nv = 0; first_valid = -1; flush_n = 0; stall_low = 0; pc_moved = 0; back_idle = 0;
            acked = 1'b0; done = 1'b0; pc0 = '0;
            @(negedge clk);
            valid = 1'b1; ir = (kind == 1) ? MRET : ECALL; mtvec = tv; mepc = ev;
            mem_busy = 1'b0; redir_ack = 1'b0;
            for (int c = 1; c <= 40 && !done; c++) begin
                @(negedge clk);
                if (acked) begin
                    valid = 1'b0; redir_ack = 1'b0;
                    #1;
                    back_idle = (busy === 1'b0) ? 1 : 0;
                    done = 1'b1;
                end else begin
                    valid = $urandom_range(0, 1);
                    case ($urandom_range(0, 2))
                        0: ir = ECALL;
                        1: ir = MRET;
                        default: ir = $urandom;
                    endcase
                    mem_busy = (c <= k);
                    if (nv > 0) begin mtvec = $urandom; mepc = $urandom; end
                    else begin mtvec = tv2; mepc = ev2; end
                    #1;
                    if (flush === 1'b1) flush_n++;
                    if (stall !== 1'b1) stall_low++;
                    if (redir_valid === 1'b1) begin
                        nv++;
                        if (first_valid < 0) begin first_valid = c; pc0 = redir_pc; end
                        else if (redir_pc !== pc0) pc_moved++;
                    end
                    if (redir_valid === 1'b1 && nv == d + 1) begin redir_ack = 1'b1; acked = 1'b1; end
                end
            end
            valid = 1'b0; redir_ack = 1'b0; mem_busy = 1'b0;
            if (acked) exp_count = exp_count + 1;
            n_cmp++; if (!done) begin n_fail++; $display("[TB] FAIL rand%0d_timeout: got no return want return within 40 cycles", t); end
            n_cmp++; if (first_valid !== exp_first) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", t, first_valid, exp_first); end
            n_cmp++; if (pc0 !== exp_pc) begin n_fail++; $display("[TB] FAIL rand%0d_target: got %h want %h", t, pc0, exp_pc); end
            n_cmp++; if (nv !== d + 1) begin n_fail++; $display("[TB] FAIL rand%0d_valid_cycles: got %0d want %0d", t, nv, d + 1); end
            n_cmp++; if (flush_n !== 1) begin n_fail++; $display("[TB] FAIL rand%0d_flush: got %0d want 1", t, flush_n); end
            n_cmp++; if (stall_low !== 0 || pc_moved !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_hold: got stall_low %0d pc_moved %0d want 0 0", t, stall_low, pc_moved); end
            n_cmp++; if (back_idle !== 1) begin n_fail++; $display("[TB] FAIL rand%0d_idle: got %0d want 1", t, back_idle); end
            n_cmp++; if (trap_count !== exp_count) begin n_fail++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", t, trap_count, exp_count); end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_drain_stall();
        test_handshake();
        test_halt();
        test_non_trap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
